section_range_buffer: RTL and testbench

SECTION_RANGE_BUFFER -- requirements
Module: section_range_buffer

---
 rtl/section_buffer_pkg.sv | 13 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/section_range_buffer.sv | 139 +++++++++++++
 tb/tb_section_range_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/section_buffer_pkg.sv
// Shared constants and helpers for the section range buffer.
// Result modes and the channel-tag width rule live here so every file agrees on them.
package section_buffer_pkg;

   localparam int MODE_RANGE = 0;
   localparam int MODE_PEAK  = 1;

   // Channel tags stay at least one bit wide even with a single channel.
   function automatic int chan_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on data whenever empty is low.
// A push into a full FIFO is taken only if a pop happens on the same edge.
module sync_fifo #(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [width-1:0] data
);

   localparam int AW = (depth > 1) ? $clog2(depth) : 1;

   logic [width-1:0] mem_reg [depth];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   // The extra pointer bit tells full from empty when the address bits match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   assign data = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/section_range_buffer.sv
// Per-channel section statistics (range or peak) over interleaved samples,
// with completed results queued in completion order through a small FIFO.
module section_range_buffer
   import section_buffer_pkg::*;
#(
   parameter int width        = 16,
   parameter int channels     = 2,
   parameter int sample_count = 4,
   parameter int buffer_depth = 4,
   parameter int mode         = MODE_RANGE,
   parameter int is_signed    = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_valid,
   output logic                            i_ready,
   input  logic [width-1:0]                i_value,
   input  logic [chan_width(channels)-1:0] i_channel,
   output logic                            o_valid,
   input  logic                            o_ready,
   output logic [width-1:0]                o_value,
   output logic [chan_width(channels)-1:0] o_channel,
   output logic                            o_overflow
);

   localparam int CW    = chan_width(channels);
   localparam int CNT_W = $clog2(sample_count);

   logic                              accept;
   logic [channels-1:0]               last;
   logic [channels-1:0][width-1:0]    sec_max;
   logic [channels-1:0][width-1:0]    sec_min;
   logic                              push_req;
   logic [width-1:0]                  sel_max;
   logic [width-1:0]                  sel_min;
   logic [CW-1:0]                     sel_chan;
   logic [width-1:0]                  result;
   logic [width-1:0]                  abs_max;
   logic [width-1:0]                  abs_min;
   logic                              fifo_full;
   logic                              fifo_empty;
   logic                              pop;
   logic [CW+width-1:0]               fifo_data;
   logic                              overflow_reg;

   function automatic logic greater(input logic [width-1:0] a, input logic [width-1:0] b);
      if (is_signed != 0) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   // Magnitude of a signed sample; the most negative value clips to the largest positive one.
   function automatic logic [width-1:0] abs_sat(input logic [width-1:0] x);
      if (!x[width-1]) return x;
      if (x == {1'b1, {(width-1){1'b0}}}) return {1'b0, {(width-1){1'b1}}};
      return '0 - x;
   endfunction

   assign i_ready = reset && (!fifo_full || o_ready);
   assign accept  = i_valid && i_ready;

   for (genvar gi = 0; gi < channels; gi++) begin : g_chan
      logic [CNT_W-1:0] count_reg;
      logic [width-1:0] max_reg;
      logic [width-1:0] min_reg;
      logic             hit;
      logic             first;

      assign hit         = accept && (i_channel == CW'(gi));
      assign first       = (count_reg == '0);
      assign sec_max[gi] = (first || greater(i_value, max_reg)) ? i_value : max_reg;
      assign sec_min[gi] = (first || greater(min_reg, i_value)) ? i_value : min_reg;
      assign last[gi]    = hit && (count_reg == CNT_W'(sample_count - 1));

      always_ff @(posedge clk) begin
         if (!reset) begin
            count_reg <= '0;
            max_reg   <= '0;
            min_reg   <= '0;
         end else if (hit) begin
            count_reg <= last[gi] ? '0 : count_reg + CNT_W'(1);
            max_reg   <= sec_max[gi];
            min_reg   <= sec_min[gi];
         end
      end
   end

   // At most one channel can complete per edge, since only one sample arrives.
   always_comb begin
      push_req = 1'b0;
      sel_max  = '0;
      sel_min  = '0;
      sel_chan = '0;
      for (int i = 0; i < channels; i++) begin
         if (last[i]) begin
            push_req = 1'b1;
            sel_max  = sec_max[i];
            sel_min  = sec_min[i];
            sel_chan = CW'(i);
         end
      end
   end

   always_comb begin
      abs_max = abs_sat(sel_max);
      abs_min = abs_sat(sel_min);
      result  = sel_max - sel_min;
      if (mode == MODE_PEAK) begin
         if (is_signed != 0) result = (abs_max > abs_min) ? abs_max : abs_min;
         else                result = sel_max;
      end
   end

   assign pop = o_valid && o_ready;

   sync_fifo #(
      .width (CW + width),
      .depth (buffer_depth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data ({sel_chan, result}),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .data      (fifo_data)
   );

   always_ff @(posedge clk) begin
      if (!reset)                              overflow_reg <= 1'b0;
      else if (push_req && fifo_full && !pop)  overflow_reg <= 1'b1;
   end

   assign o_valid    = !fifo_empty;
   assign o_value    = fifo_empty ? '0 : fifo_data[width-1:0];
   assign o_channel  = fifo_empty ? '0 : fifo_data[CW+width-1:width];
   assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_section_range_buffer.sv
// Directed bench: range DUT driven from a vector table, plus peak-signed and
// three-channel instances exercised by hand-written corner sequences.
module tb_section_range_buffer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_value;
   logic [1:0]  i_channel;

   logic        d_i_ready, d_o_valid, d_o_overflow;
   logic [15:0] d_o_value;
   logic [0:0]  d_o_channel;
   logic        p_i_ready, p_o_valid, p_o_overflow;
   logic [15:0] p_o_value;
   logic [0:0]  p_o_channel;
   logic        c_i_ready, c_o_valid, c_o_overflow;
   logic [15:0] c_o_value;
   logic [1:0]  c_o_channel;

   section_range_buffer #(.width(16), .channels(2), .sample_count(4), .buffer_depth(4),
                          .mode(0), .is_signed(0)) u_dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(d_i_ready),
      .i_value(i_value), .i_channel(i_channel[0:0]), .o_valid(d_o_valid),
      .o_ready(o_ready), .o_value(d_o_value), .o_channel(d_o_channel),
      .o_overflow(d_o_overflow));

   section_range_buffer #(.width(16), .channels(2), .sample_count(4), .buffer_depth(4),
                          .mode(1), .is_signed(1)) u_peak (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(p_i_ready),
      .i_value(i_value), .i_channel(i_channel[0:0]), .o_valid(p_o_valid),
      .o_ready(o_ready), .o_value(p_o_value), .o_channel(p_o_channel),
      .o_overflow(p_o_overflow));

   section_range_buffer #(.width(16), .channels(3), .sample_count(4), .buffer_depth(4),
                          .mode(0), .is_signed(0)) u_ch3 (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(c_i_ready),
      .i_value(i_value), .i_channel(i_channel), .o_valid(c_o_valid),
      .o_ready(o_ready), .o_value(c_o_value), .o_channel(c_o_channel),
      .o_overflow(c_o_overflow));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: %h", name, act);
      end
   endtask

   // Present one sample at a falling edge and hold it until it is accepted.
   task automatic send(input logic [1:0] ch, input logic [15:0] v);
      int waited = 0;
      i_valid   = 1'b1;
      i_channel = ch;
      i_value   = v;
      #1;
      while (!d_i_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!d_i_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL send_timeout: i_ready stuck at %b, expected 1", d_i_ready);
      end
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      i_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   logic        mon_en = 1'b0;
   logic [16:0] mon_q[$];
   always @(negedge clk) begin
      #1;
      if (mon_en && d_o_valid && o_ready) mon_q.push_back({d_o_channel, d_o_value});
   end

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] val;
      logic        exp_valid;
      logic [15:0] exp_value;
      logic [1:0]  exp_ch;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{2'd0, 16'h1111, 1'b0, 16'h0000, 2'd0};
      vecs[1]  = '{2'd0, 16'h1111, 1'b0, 16'h0000, 2'd0};
      vecs[2]  = '{2'd0, 16'h1111, 1'b0, 16'h0000, 2'd0};
      vecs[3]  = '{2'd0, 16'h1111, 1'b1, 16'h0000, 2'd0};
      vecs[4]  = '{2'd0, 16'h6666, 1'b0, 16'h0000, 2'd0};
      vecs[5]  = '{2'd1, 16'h7777, 1'b0, 16'h0000, 2'd0};
      vecs[6]  = '{2'd0, 16'h2222, 1'b0, 16'h0000, 2'd0};
      vecs[7]  = '{2'd1, 16'h1111, 1'b0, 16'h0000, 2'd0};
      vecs[8]  = '{2'd0, 16'h2222, 1'b0, 16'h0000, 2'd0};
      vecs[9]  = '{2'd1, 16'h4444, 1'b0, 16'h0000, 2'd0};
      vecs[10] = '{2'd0, 16'h5555, 1'b1, 16'h4444, 2'd0};
      vecs[11] = '{2'd1, 16'h2222, 1'b1, 16'h6666, 2'd1};
      vecs[12] = '{2'd1, 16'h0005, 1'b0, 16'h0000, 2'd0};
      vecs[13] = '{2'd1, 16'hFFFF, 1'b0, 16'h0000, 2'd0};
      vecs[14] = '{2'd1, 16'h0000, 1'b0, 16'h0000, 2'd0};
      vecs[15] = '{2'd1, 16'h0010, 1'b1, 16'hFFFF, 2'd1};

      reset     = 1'b0;
      i_valid   = 1'b0;
      i_value   = '0;
      i_channel = '0;
      o_ready   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_o_valid",    {31'd0, d_o_valid},    32'd0);
      chk("rst_i_ready",    {31'd0, d_i_ready},    32'd0);
      chk("rst_o_value",    {16'd0, d_o_value},    32'd0);
      chk("rst_o_channel",  {31'd0, d_o_channel},  32'd0);
      chk("rst_o_overflow", {31'd0, d_o_overflow}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_i_ready", {31'd0, d_i_ready}, 32'd1);

      // Table: one sample per cycle, result checked one cycle after the completing edge.
      for (int i = 0; i < 16; i++) begin
         send(vecs[i].ch, vecs[i].val);
         chk($sformatf("vec%0d_valid", i), {31'd0, d_o_valid}, {31'd0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_value", i), {16'd0, d_o_value}, {16'd0, vecs[i].exp_value});
            chk($sformatf("vec%0d_chan", i), {31'd0, d_o_channel}, {30'd0, vecs[i].exp_ch});
         end
      end

      // Signed peak with a most-negative sample saturating.
      do_reset();
      send(2'd0, 16'hFFFE);
      send(2'd0, 16'h0003);
      send(2'd0, 16'h8000);
      send(2'd0, 16'h0001);
      chk("peak_valid", {31'd0, p_o_valid}, 32'd1);
      chk("peak_value", {16'd0, p_o_value}, 32'h7FFF);
      chk("peak_chan",  {31'd0, p_o_channel}, 32'd0);
      chk("peak_range_value", {16'd0, d_o_value}, 32'hFFFD);

      // Backpressure: four results fill the FIFO, the fifth waits for the consumer.
      do_reset();
      o_ready = 1'b0;
      mon_q.delete();
      mon_en = 1'b1;
      for (int s = 1; s <= 4; s++) begin
         send(2'd0, 16'h0000);
         send(2'd0, 16'(s * 16'h0111));
         send(2'd0, 16'h0000);
         send(2'd0, 16'h0000);
      end
      #1;
      chk("full_i_ready", {31'd0, d_i_ready}, 32'd0);
      chk("full_head",    {16'd0, d_o_value}, 32'h0111);
      @(negedge clk);
      chk("stall_head_stable", {16'd0, d_o_value}, 32'h0111);
      o_ready = 1'b1;
      send(2'd0, 16'h0000);
      send(2'd0, 16'h0555);
      send(2'd0, 16'h0000);
      send(2'd0, 16'h0000);
      repeat (8) @(negedge clk);
      mon_en = 1'b0;
      chk("drain_count", mon_q.size(), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < mon_q.size())
            chk($sformatf("drain%0d", k), {15'd0, mon_q[k]}, {15'd0, 1'b0, 16'((k + 1) * 16'h0111)});
      end
      chk("drain_overflow", {31'd0, d_o_overflow}, 32'd0);
      chk("drain_empty", {31'd0, d_o_valid}, 32'd0);

      // Reset mid-section throws away the partial samples.
      do_reset();
      send(2'd0, 16'h9999);
      send(2'd0, 16'h8888);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_o_valid", {31'd0, d_o_valid}, 32'd0);
      chk("midrst_i_ready", {31'd0, d_i_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      send(2'd0, 16'h1111);
      send(2'd0, 16'h2222);
      chk("midrst_no_early", {31'd0, d_o_valid}, 32'd0);
      send(2'd0, 16'h3333);
      send(2'd0, 16'h4444);
      chk("midrst_valid", {31'd0, d_o_valid}, 32'd1);
      chk("midrst_value", {16'd0, d_o_value}, 32'h3333);
      @(negedge clk);
      chk("midrst_single", {31'd0, d_o_valid}, 32'd0);

      // Out-of-range channel tag is swallowed without touching channel 1.
      do_reset();
      send(2'd1, 16'h2222);
      send(2'd1, 16'h2222);
      send(2'd3, 16'h7777);
      chk("badch_no_result", {31'd0, c_o_valid}, 32'd0);
      send(2'd1, 16'h2222);
      send(2'd1, 16'h2222);
      chk("badch_valid", {31'd0, c_o_valid}, 32'd1);
      chk("badch_value", {16'd0, c_o_value}, 32'h0000);
      chk("badch_chan",  {30'd0, c_o_channel}, 32'd1);
      @(negedge clk);
      chk("badch_no_extra", {31'd0, c_o_valid}, 32'd0);
      chk("badch_overflow", {31'd0, c_o_overflow}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
